// File: rtl/rom_mac_sequencer.sv
// rom_mac_sequencer: walks two ROM address runs in lockstep and
// accumulates the ROM product output into a sum-of-products result.
module rom_mac_sequencer #(
   parameter int DATA_WIDTH = 4,
   parameter int ADDR_WIDTH = 6,
   parameter int ACC_WIDTH  = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] base_a,
   input  logic [ADDR_WIDTH-1:0] base_b,
   input  logic [ADDR_WIDTH:0]   len,
   input  logic [DATA_WIDTH-1:0] rom_prod,
   output logic [ADDR_WIDTH-1:0] rom_addr_1,
   output logic [ADDR_WIDTH-1:0] rom_addr_2,
   output logic                  busy,
   output logic                  done,
   output logic [ACC_WIDTH-1:0]  result,
   output logic                  overflow
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] addr1_nx, addr2_nx;
   logic [ADDR_WIDTH:0]   cnt, cnt_nx;
   logic [ACC_WIDTH-1:0]  acc, acc_nx;
   logic [ACC_WIDTH-1:0]  result_nx;
   logic                  ovf, ovf_nx;
   logic                  overflow_nx;
   logic [ACC_WIDTH:0]    sum;

   // Extra top bit of the sum is the carry out of the accumulator.
   assign sum = {1'b0, acc}
              + {{(ACC_WIDTH + 1 - DATA_WIDTH){1'b0}}, rom_prod};

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rom_addr_1 <= '0;
         rom_addr_2 <= '0;
         cnt        <= '0;
         acc        <= '0;
         ovf        <= 1'b0;
         result     <= '0;
         overflow   <= 1'b0;
      end else begin
         state      <= state_nx;
         rom_addr_1 <= addr1_nx;
         rom_addr_2 <= addr2_nx;
         cnt        <= cnt_nx;
         acc        <= acc_nx;
         ovf        <= ovf_nx;
         result     <= result_nx;
         overflow   <= overflow_nx;
      end
   end

   // Next-state and next-datapath logic; everything holds by default.
   always_comb begin
      state_nx    = state;
      addr1_nx    = rom_addr_1;
      addr2_nx    = rom_addr_2;
      cnt_nx      = cnt;
      acc_nx      = acc;
      ovf_nx      = ovf;
      result_nx   = result;
      overflow_nx = overflow;
      unique case (state)
         IDLE: begin
            if (start) begin
               acc_nx = '0;
               ovf_nx = 1'b0;
               if (len == '0) begin
                  result_nx   = '0;
                  overflow_nx = 1'b0;
                  state_nx    = DONE;
               end else begin
                  addr1_nx = base_a;
                  addr2_nx = base_b;
                  cnt_nx   = len;
                  state_nx = RUN;
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_nx = IDLE;
            end else begin
               acc_nx   = sum[ACC_WIDTH-1:0];
               ovf_nx   = ovf | sum[ACC_WIDTH];
               addr1_nx = rom_addr_1 + 1'b1;
               addr2_nx = rom_addr_2 + 1'b1;
               cnt_nx   = cnt - 1'b1;
               if (cnt == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
                  result_nx   = acc_nx;
                  overflow_nx = ovf_nx;
                  state_nx    = DONE;
               end
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_rom_mac_sequencer.sv
// tb_rom_mac_sequencer: table-driven runs against a behavioural ROM,
// with a result scoreboard and hand-written abort/reset sequences.
module tb_rom_mac_sequencer;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic [5:0] base_a;
   logic [5:0] base_b;
   logic [6:0] len;
   logic [3:0] rom_prod;
   logic [5:0] rom_addr_1;
   logic [5:0] rom_addr_2;
   logic       busy;
   logic       done;
   logic [9:0] result;
   logic       overflow;

   logic       force_en;
   logic [3:0] force_val;

   int pass_cnt;
   int total_cnt;

   typedef struct {
      int ba;
      int bb;
      int ln;
      int er;
      int eo;
   } vec_t;

   typedef struct {
      int r;
      int o;
   } exp_t;

   vec_t vecs[5];
   exp_t sb[$];

   rom_mac_sequencer #(
      .DATA_WIDTH(4),
      .ADDR_WIDTH(6),
      .ACC_WIDTH (10)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .base_a    (base_a),
      .base_b    (base_b),
      .len       (len),
      .rom_prod  (rom_prod),
      .rom_addr_1(rom_addr_1),
      .rom_addr_2(rom_addr_2),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .overflow  (overflow)
   );

   // Bench ROM: rom[i] = i mod 16, product truncated to 4 bits.
   function automatic logic [3:0] rom_model(input logic [5:0] a,
                                            input logic [5:0] b);
      logic [7:0] p;
      p = a[3:0] * b[3:0];
      return p[3:0];
   endfunction

   assign rom_prod = force_en ? force_val
                              : rom_model(rom_addr_1, rom_addr_2);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      total_cnt++;
      if (act !== exp)
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      else
         pass_cnt++;
   endtask

   task automatic run(input int ba, input int bb, input int ln,
                      input int er, input int eo);
      int         cyc;
      logic [5:0] pa1;
      logic [5:0] pa2;
      exp_t       e;
      @(negedge clk);
      pa1    = rom_addr_1;
      pa2    = rom_addr_2;
      base_a = ba[5:0];
      base_b = bb[5:0];
      len    = ln[6:0];
      start  = 1'b1;
      sb.push_back('{er, eo});
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      while (!done && cyc <= ln + 5) begin
         if (cyc <= ln) begin
            check("addr1", rom_addr_1, (ba + cyc - 1) % 64);
            check("addr2", rom_addr_2, (bb + cyc - 1) % 64);
            check("busy_run", busy, 1);
         end
         @(negedge clk);
         cyc++;
      end
      check("done_latency", cyc, ln + 1);
      check("busy_done", busy, 1);
      if (ln == 0) begin
         check("addr1_hold", rom_addr_1, pa1);
         check("addr2_hold", rom_addr_2, pa2);
      end
      if (sb.size() == 0) begin
         check("sb_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         check("result", result, e.r);
         check("overflow", overflow, e.o);
      end
      @(negedge clk);
      check("done_pulse", done, 0);
      check("busy_after", busy, 0);
   endtask

   initial begin
      int   dcount;
      bit   seen;
      exp_t e;
      pass_cnt  = 0;
      total_cnt = 0;
      vecs[0] = '{1, 2, 3, 20, 0};
      vecs[1] = '{7, 9, 0, 0, 0};
      vecs[2] = '{5, 5, 2, 13, 0};
      vecs[3] = '{15, 15, 1, 1, 0};
      vecs[4] = '{62, 0, 4, 18, 0};

      rst_n     = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      base_a    = '0;
      base_b    = '0;
      len       = '0;
      force_en  = 1'b0;
      force_val = '0;
      #2;
      check("rst_addr1", rom_addr_1, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_ovf", overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++)
         run(vecs[i].ba, vecs[i].bb, vecs[i].ln, vecs[i].er, vecs[i].eo);

      // Abort in RUN cycle 3 of a len=10 run.
      @(negedge clk);
      base_a = 6'd3;
      base_b = 6'd4;
      len    = 7'd10;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_result", result, 18);
      check("abort_ovf", overflow, 0);
      dcount = 0;
      for (int i = 0; i < 15; i++) begin
         if (done) dcount++;
         @(negedge clk);
      end
      check("abort_no_done", dcount, 0);

      // Overflow run, then a clean run clears the sticky flag.
      force_en  = 1'b1;
      force_val = 4'd15;
      run(0, 0, 70, 26, 1);
      force_val = 4'd5;
      run(0, 0, 1, 5, 0);
      force_en = 1'b0;

      // start held through RUN and DONE yields a single done.
      @(negedge clk);
      base_a = 6'd1;
      base_b = 6'd2;
      len    = 7'd3;
      start  = 1'b1;
      sb.push_back('{20, 0});
      dcount = 0;
      seen   = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (seen) start = 1'b0;
         if (done) begin
            dcount++;
            seen = 1'b1;
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("held_result", result, e.r);
            end
         end
      end
      check("held_one_done", dcount, 1);
      check("held_idle", busy, 0);

      // Asynchronous reset mid-run.
      @(negedge clk);
      base_a = 6'd3;
      base_b = 6'd4;
      len    = 7'd10;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_addr1", rom_addr_1, 0);
      check("arst_addr2", rom_addr_2, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_result", result, 0);
      check("arst_ovf", overflow, 0);
      @(negedge clk);
      rst_n  = 1'b1;
      dcount = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) dcount++;
         @(negedge clk);
      end
      check("arst_no_done", dcount, 0);
      run(1, 2, 3, 20, 0);
      check("sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/rom_mac_sequencer.md
# rom_mac_sequencer

Sequencer that drives the dual-address product ROM to compute a sum of products over two address runs: result = Σ rom[base_a+i]·rom[base_b+i], i = 0..len−1. It owns both ROM address ports, steps them one pair per clock, accumulates the ROM's product output, and reports the sum with a one-cycle done pulse. It sits between a host/control FSM and the product ROM instance.

## Interface
- DATA_WIDTH, 4, ROM word and product width; matches the ROM's data_out.
- ADDR_WIDTH, 6, ROM address width.
- ACC_WIDTH, 10, accumulator/result width; must be ≥ DATA_WIDTH.

- clk  in  1  single system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a run; sampled only in IDLE.
- abort  in  1  cancel a run in progress; sampled only in RUN.
- base_a  in  ADDR_WIDTH  first address of run A; latched on accepted start.
- base_b  in  ADDR_WIDTH  first address of run B; latched on accepted start.
- len  in  ADDR_WIDTH+1  number of pairs; latched on accepted start.
- rom_prod  in  DATA_WIDTH  product from the ROM, rom[rom_addr_1]·rom[rom_addr_2].
- rom_addr_1  out  ADDR_WIDTH  to ROM addr_1; registered.
- rom_addr_2  out  ADDR_WIDTH  to ROM addr_2; registered.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse, result valid.
- result  out  ACC_WIDTH  last completed sum; held until next completion.
- overflow  out  1  sticky per run: carry out of ACC_WIDTH occurred.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. On start=1: latch inputs, acc←0, ovf←0. len=0 → DONE directly. Else rom_addr_1←base_a, rom_addr_2←base_b, cnt←len → RUN.
- RUN, each cycle: acc←acc+rom_prod (zero-extended, mod 2^ACC_WIDTH); ovf←ovf | carry; both addresses +1 mod 2^ADDR_WIDTH; cnt←cnt−1. When cnt=1 at the edge → DONE. start ignored.
- abort=1 in RUN → IDLE at that edge; that cycle's product not accumulated; no done; result/overflow unchanged.
- DONE: done=1 for exactly one cycle; result/overflow show the run's acc/ovf (registered on entry); → IDLE.
- Addresses hold last value in IDLE/DONE. len>2^ADDR_WIDTH legal; addresses wrap and revisit.
- rst_n low (any time, including mid-run): state IDLE; rom_addr_1=rom_addr_2=0, busy=0, done=0, result=0, overflow=0, acc=0, cnt=0. No done for the interrupted run.

## Timing
- ROM captures addresses on the falling clk edge; rom_prod for the address pair presented during cycle k is stable before the rising edge ending cycle k and is accumulated at that edge. No extra pipeline stage.
- start sampled at edge 0 (len=N≥1): RUN cycles 1..N, accumulate at edges 1..N, done high during cycle N+1, busy low from cycle N+2. Next start accepted at the edge ending cycle N+1 is ignored (state DONE); earliest accepted start at edge N+2.
- len=0: done high during cycle 1, result=0, overflow=0.
- Throughput: one pair per clock; run overhead 2 cycles.

## Test plan
- Bench ROM rom[i]=i mod 16, prod truncated to 4 bits: base_a=1, base_b=2, len=3 → products 2,6,12; done in cycle 4 after start, result=20, overflow=0, addresses 1..3 / 2..4 on successive cycles.
- len=0, any bases → done in cycle 1, result=0, rom_addr unchanged, busy high exactly 1 cycle.
- Wrap: base_a=62, base_b=0, len=4 → rom_addr_1 62,63,0,1; products 0,15,0,3; result=18.
- Overflow: rom_prod forced to 15, len=70 → result=1050 mod 1024=26, overflow=1; following run len=1 with prod 5 → result=5, overflow=0.
- abort at RUN cycle 3 of len=10 → IDLE next cycle, no done, result holds previous 18; start held high during RUN/DONE of another run is ignored (one done only).
- rst_n pulsed low mid-RUN asynchronously → all outputs 0 immediately; after release, start base_a=1, base_b=2, len=3 again gives result=20.
